// File: rtl/ljpeg_row_reconstruct_if.sv
// rtl/ljpeg_row_reconstruct_if.sv - beat-level bus between the entropy decoder and row reconstruction
interface ljpeg_row_reconstruct_if #(
  parameter int PIXEL_BITS = 12
);
  logic [15:0] diffs_input, diffs_input_1, diffs_input_2, diffs_input_3;
  logic [15:0] diffs_input_4, diffs_input_5, diffs_input_6, diffs_input_7;
  logic [15:0] diffs_input_8, diffs_input_9, diffs_input_10, diffs_input_11;
  logic [15:0] diffs_input_12, diffs_input_13, diffs_input_14, diffs_input_15;
  logic        input_valid;
  logic        pause_signal;
  logic        end_in;
  logic [1:0]  predictor_select;
  logic [PIXEL_BITS-1:0] pixels_output, pixels_output_1, pixels_output_2, pixels_output_3;
  logic [PIXEL_BITS-1:0] pixels_output_4, pixels_output_5, pixels_output_6, pixels_output_7;
  logic [PIXEL_BITS-1:0] pixels_output_8, pixels_output_9, pixels_output_10, pixels_output_11;
  logic [PIXEL_BITS-1:0] pixels_output_12, pixels_output_13, pixels_output_14, pixels_output_15;
  logic        output_valid;
  logic        new_row;
  logic        end_out;

  modport master (
    output diffs_input, diffs_input_1, diffs_input_2, diffs_input_3,
           diffs_input_4, diffs_input_5, diffs_input_6, diffs_input_7,
           diffs_input_8, diffs_input_9, diffs_input_10, diffs_input_11,
           diffs_input_12, diffs_input_13, diffs_input_14, diffs_input_15,
           input_valid, pause_signal, end_in, predictor_select,
    input  pixels_output, pixels_output_1, pixels_output_2, pixels_output_3,
           pixels_output_4, pixels_output_5, pixels_output_6, pixels_output_7,
           pixels_output_8, pixels_output_9, pixels_output_10, pixels_output_11,
           pixels_output_12, pixels_output_13, pixels_output_14, pixels_output_15,
           output_valid, new_row, end_out
  );

  modport slave (
    input  diffs_input, diffs_input_1, diffs_input_2, diffs_input_3,
           diffs_input_4, diffs_input_5, diffs_input_6, diffs_input_7,
           diffs_input_8, diffs_input_9, diffs_input_10, diffs_input_11,
           diffs_input_12, diffs_input_13, diffs_input_14, diffs_input_15,
           input_valid, pause_signal, end_in, predictor_select,
    output pixels_output, pixels_output_1, pixels_output_2, pixels_output_3,
           pixels_output_4, pixels_output_5, pixels_output_6, pixels_output_7,
           pixels_output_8, pixels_output_9, pixels_output_10, pixels_output_11,
           pixels_output_12, pixels_output_13, pixels_output_14, pixels_output_15,
           output_valid, new_row, end_out
  );
endinterface

// File: rtl/ljpeg_row_reconstruct.sv
// rtl/ljpeg_row_reconstruct.sv - lossless JPEG predictor + difference reconstruction, one row of history
module ljpeg_row_reconstruct #(
  parameter int LANES      = 16,
  parameter int PIXEL_BITS = 12,
  parameter int ROW_WORDS  = 32
) (
  input  logic sys_clk,
  input  logic sys_rst,
  ljpeg_row_reconstruct_if.slave bus
);
  localparam int PB = PIXEL_BITS;
  localparam int WB = $clog2(ROW_WORDS);
  localparam int WW = LANES * PB;
  localparam logic [WB-1:0] LAST_WORD = WB'(ROW_WORDS - 1);
  localparam logic [PB-1:0] MID_GRAY  = {1'b1, {(PB-1){1'b0}}};

  logic [15:0]   diff_in [16];
  logic [PB-1:0] pix_ext [16];
  logic [PB-1:0] pix_q   [LANES];
  logic [PB-1:0] upleft_q[LANES];
  logic [PB-1:0] above   [LANES];
  logic [PB-1:0] pred    [LANES];
  logic [PB-1:0] pix_d   [LANES];
  logic [WW-1:0] mem     [ROW_WORDS];
  logic [WW-1:0] mem_rd;
  logic [WW-1:0] word_d;
  logic [WB-1:0] word_counter;
  logic          first_row;
  logic          valid_q, new_row_q, end_q;
  logic          accept;
  logic          unused_diff_hi;

  assign diff_in[0]  = bus.diffs_input;     assign diff_in[1]  = bus.diffs_input_1;
  assign diff_in[2]  = bus.diffs_input_2;   assign diff_in[3]  = bus.diffs_input_3;
  assign diff_in[4]  = bus.diffs_input_4;   assign diff_in[5]  = bus.diffs_input_5;
  assign diff_in[6]  = bus.diffs_input_6;   assign diff_in[7]  = bus.diffs_input_7;
  assign diff_in[8]  = bus.diffs_input_8;   assign diff_in[9]  = bus.diffs_input_9;
  assign diff_in[10] = bus.diffs_input_10;  assign diff_in[11] = bus.diffs_input_11;
  assign diff_in[12] = bus.diffs_input_12;  assign diff_in[13] = bus.diffs_input_13;
  assign diff_in[14] = bus.diffs_input_14;  assign diff_in[15] = bus.diffs_input_15;

  assign accept = bus.input_valid & ~bus.pause_signal;
  assign mem_rd = mem[word_counter];

  // pix_q doubles as the "left" neighbour: it is exactly the last reconstructed value per lane.
  always_comb begin
    word_d         = '0;
    unused_diff_hi = 1'b0;
    for (int i = 0; i < 16; i++) unused_diff_hi = unused_diff_hi ^ (^diff_in[i][15:PB]);
    for (int i = 0; i < LANES; i++) begin
      above[i] = mem_rd[i*PB +: PB];
      if (first_row && word_counter == '0)  pred[i] = MID_GRAY;
      else if (first_row)                   pred[i] = pix_q[i];
      else if (word_counter == '0)          pred[i] = above[i];
      else begin
        case (bus.predictor_select)
          2'd2:    pred[i] = above[i];
          2'd3:    pred[i] = upleft_q[i];
          default: pred[i] = pix_q[i];
        endcase
      end
      pix_d[i] = pred[i] + diff_in[i][PB-1:0];
      word_d[i*PB +: PB] = pix_d[i];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      word_counter <= '0;
      first_row    <= 1'b1;
      valid_q      <= 1'b0;
      new_row_q    <= 1'b1;
      end_q        <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        pix_q[i]    <= '0;
        upleft_q[i] <= '0;
      end
    end else if (!bus.pause_signal) begin
      valid_q <= bus.input_valid;
      if (bus.end_in) end_q <= 1'b1;
      if (bus.input_valid) begin
        word_counter <= word_counter + 1'b1;
        if (word_counter == LAST_WORD) first_row <= 1'b0;
        new_row_q <= (word_counter == '0);
        for (int i = 0; i < LANES; i++) begin
          pix_q[i]    <= pix_d[i];
          upleft_q[i] <= above[i];
        end
      end
    end
  end

  // Row history is deliberately not reset; first_row masks any stale contents.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && accept) mem[word_counter] <= word_d;
  end

  for (genvar g = 0; g < 16; g++) begin : g_out
    if (g < LANES) begin : g_used
      assign pix_ext[g] = pix_q[g];
    end else begin : g_pad
      assign pix_ext[g] = '0;
    end
  end

  assign bus.pixels_output    = pix_ext[0];   assign bus.pixels_output_1  = pix_ext[1];
  assign bus.pixels_output_2  = pix_ext[2];   assign bus.pixels_output_3  = pix_ext[3];
  assign bus.pixels_output_4  = pix_ext[4];   assign bus.pixels_output_5  = pix_ext[5];
  assign bus.pixels_output_6  = pix_ext[6];   assign bus.pixels_output_7  = pix_ext[7];
  assign bus.pixels_output_8  = pix_ext[8];   assign bus.pixels_output_9  = pix_ext[9];
  assign bus.pixels_output_10 = pix_ext[10];  assign bus.pixels_output_11 = pix_ext[11];
  assign bus.pixels_output_12 = pix_ext[12];  assign bus.pixels_output_13 = pix_ext[13];
  assign bus.pixels_output_14 = pix_ext[14];  assign bus.pixels_output_15 = pix_ext[15];
  assign bus.output_valid = valid_q;
  assign bus.new_row      = new_row_q;
  assign bus.end_out      = end_q;
endmodule

// File: tb/tb_ljpeg_row_reconstruct.sv
// tb/tb_ljpeg_row_reconstruct.sv - image-level model and directed checks for ljpeg_row_reconstruct
module tb_ljpeg_row_reconstruct;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ljpeg_row_reconstruct_if #(.PIXEL_BITS(12)) bus ();
  ljpeg_row_reconstruct #(.LANES(16), .PIXEL_BITS(12), .ROW_WORDS(32)) dut (
    .sys_clk(clk), .sys_rst(rst), .bus(bus)
  );

  int tests = 0, fails = 0;
  logic [15:0] d [16];
  // image model: current row being built, previous complete row
  int cur  [32][16];
  int prev [32][16];
  int m_w;
  bit m_first;
  int exp_pix [16];
  int exp_v, exp_nr, exp_end;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_pix(input int l);
    case (l)
      0: return int'(bus.pixels_output);     1: return int'(bus.pixels_output_1);
      2: return int'(bus.pixels_output_2);   3: return int'(bus.pixels_output_3);
      4: return int'(bus.pixels_output_4);   5: return int'(bus.pixels_output_5);
      6: return int'(bus.pixels_output_6);   7: return int'(bus.pixels_output_7);
      8: return int'(bus.pixels_output_8);   9: return int'(bus.pixels_output_9);
      10: return int'(bus.pixels_output_10); 11: return int'(bus.pixels_output_11);
      12: return int'(bus.pixels_output_12); 13: return int'(bus.pixels_output_13);
      14: return int'(bus.pixels_output_14); default: return int'(bus.pixels_output_15);
    endcase
  endfunction

  task automatic drive_diffs();
    bus.diffs_input    = d[0];  bus.diffs_input_1  = d[1];
    bus.diffs_input_2  = d[2];  bus.diffs_input_3  = d[3];
    bus.diffs_input_4  = d[4];  bus.diffs_input_5  = d[5];
    bus.diffs_input_6  = d[6];  bus.diffs_input_7  = d[7];
    bus.diffs_input_8  = d[8];  bus.diffs_input_9  = d[9];
    bus.diffs_input_10 = d[10]; bus.diffs_input_11 = d[11];
    bus.diffs_input_12 = d[12]; bus.diffs_input_13 = d[13];
    bus.diffs_input_14 = d[14]; bus.diffs_input_15 = d[15];
  endtask

  task automatic compare_all();
    check("output_valid", int'(bus.output_valid), exp_v);
    check("new_row", int'(bus.new_row), exp_nr);
    check("end_out", int'(bus.end_out), exp_end);
    for (int l = 0; l < 16; l++) check($sformatf("pixel_lane%0d", l), act_pix(l), exp_pix[l]);
  endtask

  // Predictor in image terms: neighbours in the row above / to the left.
  function automatic int model_pred(input int l, input int sel);
    if (m_first && m_w == 0) return 2048;
    if (m_first)             return cur[m_w-1][l];
    if (m_w == 0)            return prev[0][l];
    if (sel == 2)            return prev[m_w][l];
    if (sel == 3)            return prev[m_w-1][l];
    return cur[m_w-1][l];
  endfunction

  task automatic cycle(input bit v, input bit p, input bit e);
    bus.input_valid  = v;
    bus.pause_signal = p;
    bus.end_in       = e;
    drive_diffs();
    if (!p) begin
      if (v) begin
        for (int l = 0; l < 16; l++) begin
          cur[m_w][l] = (model_pred(l, int'(bus.predictor_select)) + int'($signed(d[l]))) & 4095;
          exp_pix[l]  = cur[m_w][l];
        end
        exp_nr = (m_w == 0) ? 1 : 0;
        m_w++;
        if (m_w == 32) begin
          m_w = 0;
          m_first = 1'b0;
          prev = cur;
        end
      end
      exp_v = v ? 1 : 0;
      if (e) exp_end = 1;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.input_valid = 1'b1; bus.pause_signal = 1'b1; bus.end_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.input_valid = 1'b0; bus.pause_signal = 1'b0; bus.end_in = 1'b0;
    m_w = 0; m_first = 1'b1;
    exp_v = 0; exp_nr = 1; exp_end = 0;
    for (int l = 0; l < 16; l++) exp_pix[l] = 0;
    compare_all();
  endtask

  task automatic zero_diffs();
    for (int l = 0; l < 16; l++) d[l] = 16'h0000;
  endtask

  initial begin
    bus.predictor_select = 2'd1;
    zero_diffs();
    drive_diffs();

    // first reset pulse also exercises reset priority over pause/valid/end
    do_reset(3);
    check("lit_reset_pix0", act_pix(0), 0);
    check("lit_reset_new_row", int'(bus.new_row), 1);

    // flat image: all zero differences
    for (int k = 0; k < 64; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check("lit_flat_pix0", act_pix(0), 2048);
      check("lit_flat_new_row", int'(bus.new_row), (k % 32 == 0) ? 1 : 0);
    end

    // left ramp on lane 0 with a pause and an idle gap mid-row
    do_reset(1);
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin
        for (int pz = 0; pz < 3; pz++) begin
          for (int l = 0; l < 16; l++) d[l] = 16'($urandom);
          cycle(1'b1, 1'b1, 1'b0);
          check("lit_pause_hold", act_pix(0), 2098);
        end
        cycle(1'b0, 1'b0, 1'b0);
        check("lit_idle_valid", int'(bus.output_valid), 0);
        check("lit_idle_hold", act_pix(0), 2098);
      end
      zero_diffs();
      d[0] = 16'd5;
      cycle(1'b1, 1'b0, 1'b0);
      check("lit_ramp_pix0", act_pix(0), 2048 + 5 * (k + 1));
    end
    zero_diffs();
    cycle(1'b1, 1'b0, 1'b0);
    check("lit_row1_word0", act_pix(0), 2053);

    // modular wrap in both directions
    do_reset(1);
    zero_diffs(); d[0] = 16'd2047;
    cycle(1'b1, 1'b0, 1'b0); check("lit_wrap_4095", act_pix(0), 4095);
    d[0] = 16'd3;
    cycle(1'b1, 1'b0, 1'b0); check("lit_wrap_up", act_pix(0), 2);
    d[0] = 16'hFFFE;
    cycle(1'b1, 1'b0, 1'b0); check("lit_wrap_zero", act_pix(0), 0);
    d[0] = 16'hFFFF;
    cycle(1'b1, 1'b0, 1'b0); check("lit_wrap_down", act_pix(0), 4095);

    // end of image alongside a beat, then reset mid-row
    d[0] = 16'd1;
    cycle(1'b1, 1'b0, 1'b1);
    check("lit_end_same_edge", int'(bus.end_out), 1);
    check("lit_end_beat_pix0", act_pix(0), 0);
    cycle(1'b1, 1'b0, 1'b0);
    check("lit_end_sticky", int'(bus.end_out), 1);
    do_reset(1);
    check("lit_rst_end_clear", int'(bus.end_out), 0);
    zero_diffs();
    cycle(1'b1, 1'b0, 1'b0);
    check("lit_rst_pred_mid", act_pix(0), 2048);
    check("lit_rst_new_row", int'(bus.new_row), 1);

    // random differences, upper-left and above predictors, with sporadic stalls
    for (int sel = 3; sel >= 2; sel--) begin
      do_reset(1);
      bus.predictor_select = 2'(sel);
      for (int k = 0; k < 64; k++) begin
        if ($urandom_range(0, 5) == 0) cycle(1'b1, 1'b1, 1'b0);
        if ($urandom_range(0, 5) == 0) cycle(1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 16; l++) d[l] = 16'($urandom);
        cycle(1'b1, 1'b0, 1'b0);
      end
    end

    // upper-left pinned by hand: row 1 word 1 takes row 0 word 0 lane 0
    do_reset(1);
    bus.predictor_select = 2'd3;
    for (int k = 0; k < 32; k++) begin
      zero_diffs(); d[0] = 16'(k + 1);
      cycle(1'b1, 1'b0, 1'b0);
    end
    zero_diffs();
    cycle(1'b1, 1'b0, 1'b0);
    check("lit_ul_word0", act_pix(0), 2049);
    cycle(1'b1, 1'b0, 1'b0);
    check("lit_ul_word1", act_pix(0), 2049);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
